pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13: PC/instruction address width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, legal 1..3: bubble cycles inserted per redirect.
REQ-003 SHALL have parameter STALL_TIMEOUT, default 255, legal 0..255: stall-cycle limit; 0 disables the watchdog.
REQ-004 SHALL have parameter IRQ_VECTOR, default 13'h0002: interrupt entry address.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port jump_flag_i  in  1  EX-stage branch/call/return taken.
REQ-008 SHALL have port jump_addr_i  in  ADDR_WIDTH  EX-stage redirect target.
REQ-009 SHALL have port pc_i  in  ADDR_WIDTH  PC of the instruction currently in EX.
REQ-010 SHALL have port mem_req_i  in  1  EX-stage multi-cycle memory/accelerator access pending.
REQ-011 SHALL have port mem_ack_i  in  1  access complete, single-cycle pulse.
REQ-012 SHALL have port irq_i  in  1  level interrupt request.
REQ-013 SHALL have port irq_ret_i  in  1  interrupt-return instruction in EX, single-cycle pulse.
REQ-014 SHALL have port pc_we_o  out  1  load PC from pc_new_o.
REQ-015 SHALL have port pc_new_o  out  ADDR_WIDTH  next PC when pc_we_o=1, else 0.
REQ-016 SHALL have port hold_o  out  1  freeze PC and IF/ID register.
REQ-017 SHALL have port flush_o  out  1  load NOP into IF/ID register.
REQ-018 SHALL have port irq_ack_o  out  1  interrupt taken, one-cycle pulse.
REQ-019 SHALL have port epc_o  out  ADDR_WIDTH  saved return address.
REQ-020 SHALL have port busy_o  out  1  FSM not in RUN.
REQ-021 SHALL have port timeout_o  out  1  sticky stall-watchdog error.

Function
REQ-022 SHALL implement FSM states RUN, FLUSH, STALL; pc_we_o, pc_new_o, flush_o, hold_o are combinational from state and inputs (same-cycle response); all other outputs registered.
REQ-023 RUN priority SHALL be: jump_flag_i > mem_req_i > irq_i.
REQ-024 RUN, jump_flag_i=1: pc_we_o=1, pc_new_o=jump_addr_i, flush_o=1 same cycle; next state FLUSH with bubble counter=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
REQ-025 FLUSH: flush_o=1, hold_o=0, counter decrements; counter reaching 0 -> RUN; jump_flag_i, mem_req_i, irq_i ignored.
REQ-026 RUN, mem_req_i=1 and mem_ack_i=0 (no jump): hold_o=1 same cycle, next state STALL; mem_req_i and mem_ack_i both 1 -> no stall, remain RUN.
REQ-027 Simultaneous jump_flag_i and mem_req_i in RUN: jump SHALL win; mem_req_i re-evaluated next RUN cycle (requester holds it).
REQ-028 STALL: hold_o=~mem_ack_i, flush_o=0; mem_ack_i=1 -> RUN; mem_ack_i in RUN or FLUSH ignored.
REQ-029 8-bit stall counter SHALL clear on STALL entry and increment each STALL cycle; when STALL_TIMEOUT!=0 and counter==STALL_TIMEOUT, timeout_o SHALL set (sticky until rst) and FSM SHALL force RUN.
REQ-030 busy_o SHALL be 1 exactly when state is FLUSH or STALL.

Reset
REQ-031 rst=1 at a clock edge SHALL force state RUN, counters 0, in-IRQ flag 0, epc_o=0, irq_ack_o=0, timeout_o=0, busy_o=0, regardless of state (mid-stall or mid-flush included).
REQ-032 While rst=1, pc_we_o=0, hold_o=0, flush_o=1, pc_new_o=0.

Configuration
REQ-033 Macro PIPE_CTRL_IRQ_EN defined: in RUN with irq_i=1, in-IRQ flag 0, no jump, no mem_req_i -> pc_we_o=1, pc_new_o=IRQ_VECTOR, flush_o=1, epc_o<=pc_i, irq_ack_o pulses next cycle, in-IRQ flag sets, FLUSH sequence per REQ-024; irq_i masked while flag set; irq_ret_i clears flag.
REQ-034 Macro PIPE_CTRL_IRQ_EN undefined: irq_i and irq_ret_i ignored, irq_ack_o and epc_o tied 0, ports retained.

Verification
REQ-035 Jump: RUN, jump_flag_i=1, jump_addr_i=13'h0100, FLUSH_CYCLES=2 -> same cycle pc_we_o=1, pc_new_o=13'h0100, flush_o=1; next cycle flush_o=1, busy_o=1; then RUN.
REQ-036 Stall: mem_req_i=1 for 4 cycles, mem_ack_i on 4th -> hold_o=1 cycles 1-3, 0 on cycle 4; RUN after.
REQ-037 Collision: jump_flag_i=1 and mem_req_i=1 same cycle -> redirect taken, hold_o=0, no STALL entry that cycle.
REQ-038 Watchdog: STALL_TIMEOUT=8, mem_ack_i never -> timeout_o=1 after 8 STALL cycles, FSM RUN, timeout_o held until rst.
REQ-039 IRQ (PIPE_CTRL_IRQ_EN): irq_i=1, pc_i=13'h0040 -> pc_new_o=13'h0002, epc_o=13'h0040, one irq_ack_o pulse; second irq_i ignored until irq_ret_i.
REQ-040 Reset mid-STALL: rst=1 during STALL -> next cycle busy_o=0, hold_o=0, timeout_o=0, state RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: redirect/stall/watchdog sequencer for the fetch pipeline; PC/hold/flush respond same cycle, status is registered.
// Interrupt entry/return support is compiled in only when PIPE_CTRL_IRQ_EN is defined.
module pipe_ctrl #(
  parameter int                    ADDR_WIDTH    = 13,
  parameter int                    FLUSH_CYCLES  = 1,
  parameter int                    STALL_TIMEOUT = 255,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR    = ADDR_WIDTH'(2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_flag_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ack_i,
  input  logic                  irq_i,
  input  logic                  irq_ret_i,
  output logic                  pc_we_o,
  output logic [ADDR_WIDTH-1:0] pc_new_o,
  output logic                  hold_o,
  output logic                  flush_o,
  output logic                  irq_ack_o,
  output logic [ADDR_WIDTH-1:0] epc_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {RUN, FLUSH, STALL} state_t;

  localparam logic [1:0] FLUSH_INIT  = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_VAL = 8'(STALL_TIMEOUT);

  state_t     state;
  logic [1:0] bubble_cnt;
  logic [7:0] stall_cnt;
  logic       irq_pending;
  logic       take_jump;
  logic       take_stall;
  logic       take_irq;

`ifdef PIPE_CTRL_IRQ_EN
  logic in_irq;

  assign irq_pending = irq_i && !in_irq;

  // Interrupt bookkeeping; entry wins over a same-cycle return.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_irq    <= 1'b0;
      epc_o     <= '0;
      irq_ack_o <= 1'b0;
    end else begin
      irq_ack_o <= take_irq;
      if (take_irq) begin
        in_irq <= 1'b1;
        epc_o  <= pc_i;
      end else if (irq_ret_i) begin
        in_irq <= 1'b0;
      end
    end
  end
`else
  logic unused_irq;

  assign irq_pending = 1'b0;
  assign unused_irq  = ^{irq_i, irq_ret_i, pc_i};
  assign irq_ack_o   = 1'b0;
  assign epc_o       = '0;
`endif

  // RUN-state decision: jump beats memory stall beats interrupt.
  always_comb begin
    take_jump  = 1'b0;
    take_stall = 1'b0;
    take_irq   = 1'b0;
    if (!rst && state == RUN) begin
      if (jump_flag_i)    take_jump  = 1'b1;
      else if (mem_req_i) take_stall = !mem_ack_i;
      else                take_irq   = irq_pending;
    end
  end

  always_comb begin
    pc_we_o  = 1'b0;
    pc_new_o = '0;
    hold_o   = 1'b0;
    flush_o  = 1'b0;
    if (rst) begin
      flush_o = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (take_jump) begin
            pc_we_o  = 1'b1;
            pc_new_o = jump_addr_i;
            flush_o  = 1'b1;
          end else if (take_irq) begin
            pc_we_o  = 1'b1;
            pc_new_o = IRQ_VECTOR;
            flush_o  = 1'b1;
          end
          hold_o = take_stall;
        end
        FLUSH:   flush_o = 1'b1;
        STALL:   hold_o  = !mem_ack_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      bubble_cnt <= '0;
      stall_cnt  <= '0;
      busy_o     <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (take_jump || take_irq) begin
            // The redirect cycle itself is the first bubble.
            if (FLUSH_CYCLES > 1) begin
              state      <= FLUSH;
              bubble_cnt <= FLUSH_INIT;
              busy_o     <= 1'b1;
            end
          end else if (take_stall) begin
            state     <= STALL;
            stall_cnt <= '0;
            busy_o    <= 1'b1;
          end
        end
        FLUSH: begin
          bubble_cnt <= bubble_cnt - 2'd1;
          if (bubble_cnt <= 2'd1) begin
            state  <= RUN;
            busy_o <= 1'b0;
          end
        end
        STALL: begin
          stall_cnt <= stall_cnt + 8'd1;
          if (mem_ack_i) begin
            state  <= RUN;
            busy_o <= 1'b0;
          end else if (STALL_TIMEOUT != 0 && (stall_cnt + 8'd1) == TIMEOUT_VAL) begin
            timeout_o <= 1'b1;
            state     <= RUN;
            busy_o    <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expected outputs queued at drive time, compared mid-cycle.
module tb_pipe_ctrl;
  localparam int AW = 13;

  typedef struct packed {
    logic rst; logic jump; logic [AW-1:0] jaddr; logic req; logic ack;
    logic irq; logic ret; logic [AW-1:0] pc;
  } stim_t;

  typedef struct packed {
    logic pc_we; logic [AW-1:0] pc_new; logic hold; logic flush;
    logic busy; logic tmo; logic ack; logic [AW-1:0] epc;
  } obs_t;

  logic clk, rst, jump_flag, mem_req, mem_ack, irq, irq_ret;
  logic [AW-1:0] jump_addr, pc;
  logic pc_we, hold, flush, irq_ack, busy, timeout;
  logic [AW-1:0] pc_new, epc;

  int n_checks = 0;
  int n_fail   = 0;
  obs_t exp_q[$];

  pipe_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(2), .STALL_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .pc_i(pc),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack), .irq_i(irq), .irq_ret_i(irq_ret),
    .pc_we_o(pc_we), .pc_new_o(pc_new), .hold_o(hold), .flush_o(flush),
    .irq_ack_o(irq_ack), .epc_o(epc), .busy_o(busy), .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t st(logic r, logic j, logic [AW-1:0] ja, logic rq, logic ak,
                               logic ir, logic rt, logic [AW-1:0] p);
    return '{rst: r, jump: j, jaddr: ja, req: rq, ack: ak, irq: ir, ret: rt, pc: p};
  endfunction

  function automatic obs_t ob(logic we, logic [AW-1:0] nw, logic h, logic f,
                              logic b, logic t, logic a, logic [AW-1:0] e);
    return '{pc_we: we, pc_new: nw, hold: h, flush: f, busy: b, tmo: t, ack: a, epc: e};
  endfunction

  function automatic obs_t observe();
    return '{pc_we: pc_we, pc_new: pc_new, hold: hold, flush: flush,
             busy: busy, tmo: timeout, ack: irq_ack, epc: epc};
  endfunction

  function automatic string fmt(obs_t v);
    return $sformatf("we=%b new=%h hold=%b flush=%b busy=%b tmo=%b ack=%b epc=%h",
                     v.pc_we, v.pc_new, v.hold, v.flush, v.busy, v.tmo, v.ack, v.epc);
  endfunction

  task automatic apply(stim_t s);
    rst = s.rst; jump_flag = s.jump; jump_addr = s.jaddr; mem_req = s.req;
    mem_ack = s.ack; irq = s.irq; irq_ret = s.ret; pc = s.pc;
  endtask

  task automatic test_reset();
    stim_t s[$]; obs_t e[$]; obs_t got, want;
    s.push_back(st(1, 0, 0, 0, 0, 0, 0, 0));               e.push_back(ob(0, 0, 0, 1, 0, 0, 0, 0));
    s.push_back(st(1, 1, 13'h1fff, 1, 0, 1, 0, 13'h40));   e.push_back(ob(0, 0, 0, 1, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0));               e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      #1; got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jump();
    stim_t s[$]; obs_t e[$]; obs_t got, want;
    s.push_back(st(0, 1, 13'h0100, 0, 0, 0, 0, 0));   e.push_back(ob(1, 13'h0100, 0, 1, 0, 0, 0, 0));
    s.push_back(st(0, 1, 13'h0155, 1, 0, 0, 0, 0));   e.push_back(ob(0, 0, 0, 1, 1, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0));          e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      #1; got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL jump[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    stim_t s[$]; obs_t e[$]; obs_t got, want;
    for (int k = 0; k < 3; k++) begin
      s.push_back(st(0, 0, 0, 1, 0, 0, 0, 0));
      e.push_back(ob(0, 0, 1, 0, (k > 0), 0, 0, 0));
    end
    s.push_back(st(0, 0, 0, 1, 1, 0, 0, 0));   e.push_back(ob(0, 0, 0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0));   e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 1, 1, 0, 0, 0));   e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0));   e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      #1; got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL stall[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_collision();
    stim_t s[$]; obs_t e[$]; obs_t got, want;
    s.push_back(st(0, 1, 13'h0abc, 1, 0, 0, 0, 0));   e.push_back(ob(1, 13'h0abc, 0, 1, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 1, 0, 0, 0, 0));          e.push_back(ob(0, 0, 0, 1, 1, 0, 0, 0));
    s.push_back(st(0, 0, 0, 1, 0, 0, 0, 0));          e.push_back(ob(0, 0, 1, 0, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 1, 1, 0, 0, 0));          e.push_back(ob(0, 0, 0, 0, 1, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0));          e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      #1; got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL collision[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_watchdog();
    stim_t s[$]; obs_t e[$]; obs_t got, want;
    s.push_back(st(0, 0, 0, 1, 0, 0, 0, 0));   e.push_back(ob(0, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) begin
      s.push_back(st(0, 0, 0, 1, 0, 0, 0, 0)); e.push_back(ob(0, 0, 1, 0, 1, 0, 0, 0));
    end
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0));          e.push_back(ob(0, 0, 0, 0, 0, 1, 0, 0));
    s.push_back(st(0, 1, 13'h0055, 0, 0, 0, 0, 0));   e.push_back(ob(1, 13'h0055, 0, 1, 0, 1, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0));          e.push_back(ob(0, 0, 0, 1, 1, 1, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0));          e.push_back(ob(0, 0, 0, 0, 0, 1, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      #1; got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL watchdog[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$]; obs_t e[$]; obs_t got, want;
    s.push_back(st(0, 0, 0, 1, 0, 0, 0, 0));          e.push_back(ob(0, 0, 1, 0, 0, 1, 0, 0));
    s.push_back(st(1, 0, 0, 1, 0, 0, 0, 0));          e.push_back(ob(0, 0, 0, 1, 1, 1, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0));          e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 1, 13'h0010, 0, 0, 0, 0, 0));   e.push_back(ob(1, 13'h0010, 0, 1, 0, 0, 0, 0));
    s.push_back(st(1, 0, 0, 0, 0, 0, 0, 0));          e.push_back(ob(0, 0, 0, 1, 1, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0));          e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      #1; got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_mid[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_irq();
    stim_t s[$]; obs_t e[$]; obs_t got, want;
`ifdef PIPE_CTRL_IRQ_EN
    s.push_back(st(0, 0, 0, 0, 0, 1, 0, 13'h0040));   e.push_back(ob(1, 13'h0002, 0, 1, 0, 0, 0, 13'h0000));
    s.push_back(st(0, 0, 0, 0, 0, 1, 0, 13'h0040));   e.push_back(ob(0, 0, 0, 1, 1, 0, 1, 13'h0040));
    s.push_back(st(0, 0, 0, 0, 0, 1, 0, 13'h0040));   e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 13'h0040));
    s.push_back(st(0, 0, 0, 0, 0, 1, 1, 13'h0040));   e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 13'h0040));
    s.push_back(st(0, 0, 0, 0, 0, 1, 0, 13'h0077));   e.push_back(ob(1, 13'h0002, 0, 1, 0, 0, 0, 13'h0040));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 13'h0077));   e.push_back(ob(0, 0, 0, 1, 1, 0, 1, 13'h0077));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1, 13'h0077));   e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 13'h0077));
    s.push_back(st(0, 0, 0, 1, 0, 1, 0, 13'h0033));   e.push_back(ob(0, 0, 1, 0, 0, 0, 0, 13'h0077));
    s.push_back(st(0, 0, 0, 1, 1, 1, 0, 13'h0033));   e.push_back(ob(0, 0, 0, 0, 1, 0, 0, 13'h0077));
    s.push_back(st(0, 0, 0, 0, 0, 1, 0, 13'h0033));   e.push_back(ob(1, 13'h0002, 0, 1, 0, 0, 0, 13'h0077));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 13'h0033));   e.push_back(ob(0, 0, 0, 1, 1, 0, 1, 13'h0033));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1, 13'h0033));   e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 13'h0033));
`else
    s.push_back(st(0, 0, 0, 0, 0, 1, 0, 13'h0040));   e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 1, 1, 13'h0040));   e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 1, 0, 13'h0040));   e.push_back(ob(0, 0, 0, 0, 0, 0, 0, 0));
`endif
    foreach (s[i]) begin
      apply(s[i]); exp_q.push_back(e[i]);
      #1; got = observe(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++; $display("FAIL irq[%0d]: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    apply(st(1, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_jump();
    test_stall();
    test_collision();
    test_watchdog();
    test_reset_mid();
    test_irq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
